ped_request_cond: RTL and testbench

Pedestrian push-button front end for the pedestrian traffic-light controller. Synchronises and debounces the raw button from a dedicated input pin and emits a one-cycle press pulse. Holds a latched walk request until the controller acknowledges it by entering its green (walk) phase. Sits directly upstream of the light controller; its `walk_req` drives the controller's request input, and the controller's `green_light` returns as `ack_in`.

---
 rtl/ped_request_cond.sv | 152 +++++++++++++++
 tb/tb_ped_request_cond.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_cond.sv
// ----------------------------------------------------------------------------
// ped_request_cond
//
// Pedestrian push-button front end for the pedestrian traffic-light
// controller. The raw button comes straight from a pin, so it is first
// brought into the clock domain with a two-flop synchroniser. It is then
// debounced, and every accepted released->pressed transition produces a
// one-cycle press pulse. A walk request is latched from that pulse and
// held until the downstream controller acknowledges it by entering its
// green (walk) phase. A saturating press counter is kept for diagnostics.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronised button must
//                    disagree with the stable level before the new level
//                    is accepted (legal range 2 .. 2**20)
//   BTN_ACTIVE_LOW   1 inverts btn_in at the pin, before the synchroniser
//
// Ports:
//   clk          in   single clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_in       in   raw, asynchronous, bouncing push-button
//   ack_in       in   controller green/walk indication (clk domain)
//   press_pulse  out  one-cycle pulse per debounced press
//   btn_stable   out  debounced button level, 1 = pressed
//   walk_req     out  latched pedestrian request to the controller
//   press_count  out  saturating count of debounced presses (0..15)
//
// Every output is taken directly from a flop, so there is no
// combinational path from any input to any output.
// ----------------------------------------------------------------------------
module ped_request_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       ack_in,
  output logic       press_pulse,
  output logic       btn_stable,
  output logic       walk_req,
  output logic [3:0] press_count
);

  // The debounce counter only ever has to reach DEBOUNCE_CYCLES-1, so
  // $clog2 of the cycle count is exactly wide enough.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_pol;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             cnt_done;
  logic             accept_press;
  logic             ack_d;
  logic             ack_rise;

  // Normalise polarity at the pin so everything downstream treats
  // 1 as "pressed" regardless of how the button is wired.
  assign btn_pol = btn_in ^ BTN_ACTIVE_LOW;

  // Two-flop synchroniser. btn_in is fully asynchronous to clk, so only
  // s2 is allowed to feed any further logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_pol;
      s2 <= s1;
    end
  end

  // A level change is accepted only once s2 has disagreed with the stable
  // level for DEBOUNCE_CYCLES consecutive edges: the counter covers the
  // first DEBOUNCE_CYCLES-1 of them and the acceptance itself happens on
  // the last one. accept_press singles out the released->pressed case,
  // which is the only transition that counts as a press.
  always_comb begin
    mismatch     = (s2 != btn_stable);
    cnt_done     = (cnt == CNT_MAX);
    accept_press = mismatch && cnt_done && s2;
  end

  // Debounce counter and stable level. Any single edge on which s2 agrees
  // with the stable level clears the counter, so a bounce train can never
  // accumulate towards an acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (cnt_done) begin
      btn_stable <= s2;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The press pulse is registered from the same decision that raises
  // btn_stable, so it is high during exactly the cycle after the edge on
  // which the debounced level goes 0->1. Releases never pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= accept_press;
    end
  end

  // Delayed copy of the acknowledge. Because ack_d resets to 0, an ack
  // held high across reset release is seen as a rising edge on the first
  // edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_d <= 1'b0;
    end else begin
      ack_d <= ack_in;
    end
  end

  assign ack_rise = ack_in & ~ack_d;

  // Walk request latch. The controller entering walk always clears the
  // request, even if a press is accepted on that very edge. A press made
  // while walk is already showing is not latched: the pedestrian already
  // has the crossing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_req <= 1'b0;
    end else if (ack_rise) begin
      walk_req <= 1'b0;
    end else if (accept_press && !ack_in) begin
      walk_req <= 1'b1;
    end
  end

  // Saturating press counter. It counts every accepted press, including
  // those that did not set walk_req, and sticks at 15 until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= 4'd0;
    end else if (accept_press && (press_count != 4'd15)) begin
      press_count <= press_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_ped_request_cond.sv
// ----------------------------------------------------------------------------
// tb_ped_request_cond
//
// Bench for ped_request_cond with DEBOUNCE_CYCLES = 4. Two instances share
// the clock, reset and acknowledge: u_dut is active-high, u_al is
// active-low. Each cycle the stimulus and the expected post-edge outputs of
// both instances are queued together. The record is popped and compared
// one time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ped_request_cond;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       btn_al;
  logic       ack;

  logic       press_pulse;
  logic       btn_stable;
  logic       walk_req;
  logic [3:0] press_count;

  logic       al_press_pulse;
  logic       al_btn_stable;
  logic       al_walk_req;
  logic [3:0] al_press_count;

  int total;
  int bad;
  int step;

  // One table row: inputs held for 'reps' cycles, with the same expected
  // outputs of the active-high instance after each of those edges.
  typedef struct {
    logic       btn;
    logic       ack;
    int         reps;
    logic       stable;
    logic       pulse;
    logic       walk;
    logic [3:0] count;
  } vec_t;

  // Scoreboard entry: expected outputs of both instances after one edge.
  typedef struct {
    int         tag;
    logic       stable;
    logic       pulse;
    logic       walk;
    logic [3:0] count;
    logic       al_stable;
    logic       al_pulse;
    logic       al_walk;
    logic [3:0] al_count;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  ped_request_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1'b0)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn),
    .ack_in     (ack),
    .press_pulse(press_pulse),
    .btn_stable (btn_stable),
    .walk_req   (walk_req),
    .press_count(press_count)
  );

  ped_request_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1'b1)
  ) u_al (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_al),
    .ack_in     (ack),
    .press_pulse(al_press_pulse),
    .btn_stable (al_btn_stable),
    .walk_req   (al_walk_req),
    .press_count(al_press_count)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Build one expected-output record.
  function automatic exp_t mkExp(input logic s, input logic p, input logic w, input logic [3:0] c,
                                 input logic as_, input logic ap, input logic aw, input logic [3:0] ac);
    exp_t e;
    e.tag       = step;
    e.stable    = s;
    e.pulse     = p;
    e.walk      = w;
    e.count     = c;
    e.al_stable = as_;
    e.al_pulse  = ap;
    e.al_walk   = aw;
    e.al_count  = ac;
    return e;
  endfunction

  // Single comparison with the failure report.
  task automatic cmp(input string name, input int tag, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s step=%0d got=%0h want=%0h", name, tag, got, want);
    end
  endtask

  // Drive inputs on the falling edge and queue the expected result.
  task automatic applyStimulus(input logic b, input logic b_al, input logic a, input exp_t e);
    @(negedge clk);
    btn    = b;
    btn_al = b_al;
    ack    = a;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare every output of both instances.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty step=%0d got=0 want=1", step);
    end else begin
      e = sb.pop_front();
      cmp("btn_stable",     e.tag, {3'b0, btn_stable},     {3'b0, e.stable});
      cmp("press_pulse",    e.tag, {3'b0, press_pulse},    {3'b0, e.pulse});
      cmp("walk_req",       e.tag, {3'b0, walk_req},       {3'b0, e.walk});
      cmp("press_count",    e.tag, press_count,            e.count);
      cmp("al_btn_stable",  e.tag, {3'b0, al_btn_stable},  {3'b0, e.al_stable});
      cmp("al_press_pulse", e.tag, {3'b0, al_press_pulse}, {3'b0, e.al_pulse});
      cmp("al_walk_req",    e.tag, {3'b0, al_walk_req},    {3'b0, e.al_walk});
      cmp("al_press_count", e.tag, al_press_count,         e.al_count);
    end
  endtask

  // One full cycle: drive, let the rising edge happen, then check.
  task automatic stepCycle(input logic b, input logic b_al, input logic a, input exp_t e);
    applyStimulus(b, b_al, a, e);
    @(posedge clk);
    #1;
    checkOutput();
    step++;
  endtask

  // Assert reset in the middle of the high phase, check that every output
  // is already cleared without any clock edge, then release it well
  // before the next rising edge with the requested button level.
  task automatic midCycleReset(input logic hold_btn);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mkExp(0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    checkOutput();
    step++;
    btn   = hold_btn;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] cnt_exp;
    logic       walk_exp;

    total  = 0;
    bad    = 0;
    step   = 0;
    rst_n  = 1'b1;
    btn    = 1'b0;
    btn_al = 1'b1;
    ack    = 1'b0;

    // Vector table for the active-high instance (active-low held released).
    // A press driven on row r is accepted on row r+5 (DEB+1 edges later).
    // Idle after reset release.
    vecs.push_back('{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, 4'd0});
    // Clean press, then release.
    vecs.push_back('{1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1, 4'd1});
    vecs.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 4'd1});
    vecs.push_back('{1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b1, 4'd1});
    vecs.push_back('{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 4'd1});
    // Ack clears walk_req on the first edge it is seen high.
    vecs.push_back('{1'b0, 1'b1, 2,  1'b0, 1'b0, 1'b0, 4'd1});
    // Press during ack: counted but not latched.
    vecs.push_back('{1'b1, 1'b1, 5,  1'b0, 1'b0, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b0, 4'd2});
    vecs.push_back('{1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b0, 4'd2});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 4'd2});
    // Ack dropped, press again sets walk_req.
    vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 4'd3});
    // Bounce train 1,0,1,0,... for 8 cycles, then quiet.
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 4'd3});
      vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 4'd3});
    end
    vecs.push_back('{1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b1, 4'd3});
    // Three-cycle glitch: one mismatch short of acceptance.
    vecs.push_back('{1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b1, 4'd3});
    // Clear walk_req, then align an accepted press with the ack rising edge.
    vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 4'd3});
    vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd3});
    vecs.push_back('{1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b0, 4'd3});
    vecs.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 4'd4});
    vecs.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b0, 4'd4});
    vecs.push_back('{1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b0, 4'd4});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd4});

    $display("[TB] start, DEBOUNCE_CYCLES=%0d", DEB);

    // Initial reset asserted between edges: outputs must clear at once.
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mkExp(0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    checkOutput();
    step++;
    #1;
    rst_n = 1'b1;

    // Table-driven section.
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        stepCycle(vecs[i].btn, 1'b1, vecs[i].ack,
                  mkExp(vecs[i].stable, vecs[i].pulse, vecs[i].walk, vecs[i].count, 0, 0, 0, 4'd0));
      end
    end

    // Press held into a mid-cycle reset; still held on release, so it is
    // seen as a fresh press after the full debounce.
    $display("[TB] reset with button held");
    for (int c = 1; c <= 6; c++) begin
      if (c < 6) stepCycle(1'b1, 1'b1, 1'b0, mkExp(0, 0, 0, 4'd4, 0, 0, 0, 4'd0));
      else       stepCycle(1'b1, 1'b1, 1'b0, mkExp(1, 1, 1, 4'd5, 0, 0, 0, 4'd0));
    end
    midCycleReset(1'b1);
    for (int c = 1; c <= 7; c++) begin
      if (c < 6)       stepCycle(1'b1, 1'b1, 1'b0, mkExp(0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
      else if (c == 6) stepCycle(1'b1, 1'b1, 1'b0, mkExp(1, 1, 1, 4'd1, 0, 0, 0, 4'd0));
      else             stepCycle(1'b1, 1'b1, 1'b0, mkExp(1, 0, 1, 4'd1, 0, 0, 0, 4'd0));
    end

    // Release, then reset while a new press is only partly debounced.
    $display("[TB] reset mid-debounce");
    for (int c = 1; c <= 6; c++) begin
      if (c < 6) stepCycle(1'b0, 1'b1, 1'b0, mkExp(1, 0, 1, 4'd1, 0, 0, 0, 4'd0));
      else       stepCycle(1'b0, 1'b1, 1'b0, mkExp(0, 0, 1, 4'd1, 0, 0, 0, 4'd0));
    end
    for (int c = 1; c <= 3; c++) begin
      stepCycle(1'b1, 1'b1, 1'b0, mkExp(0, 0, 1, 4'd1, 0, 0, 0, 4'd0));
    end
    midCycleReset(1'b0);
    for (int c = 1; c <= 10; c++) begin
      stepCycle(1'b0, 1'b1, 1'b0, mkExp(0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    end

    // Seventeen clean presses: the counter must stick at 15.
    $display("[TB] saturation");
    cnt_exp  = 4'd0;
    walk_exp = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      for (int c = 1; c <= 6; c++) begin
        if (c < 6) begin
          stepCycle(1'b1, 1'b1, 1'b0, mkExp(0, 0, walk_exp, cnt_exp, 0, 0, 0, 4'd0));
        end else begin
          cnt_exp  = (n > 15) ? 4'd15 : 4'(n);
          walk_exp = 1'b1;
          stepCycle(1'b1, 1'b1, 1'b0, mkExp(1, 1, 1, cnt_exp, 0, 0, 0, 4'd0));
        end
      end
      for (int c = 1; c <= 6; c++) begin
        if (c < 6) stepCycle(1'b0, 1'b1, 1'b0, mkExp(1, 0, 1, cnt_exp, 0, 0, 0, 4'd0));
        else       stepCycle(1'b0, 1'b1, 1'b0, mkExp(0, 0, 1, cnt_exp, 0, 0, 0, 4'd0));
      end
    end

    // Active-low instance: pin held low is a press.
    $display("[TB] active-low button");
    for (int c = 1; c <= 7; c++) begin
      if (c < 6)       stepCycle(1'b0, 1'b0, 1'b0, mkExp(0, 0, 1, 4'd15, 0, 0, 0, 4'd0));
      else if (c == 6) stepCycle(1'b0, 1'b0, 1'b0, mkExp(0, 0, 1, 4'd15, 1, 1, 1, 4'd1));
      else             stepCycle(1'b0, 1'b0, 1'b0, mkExp(0, 0, 1, 4'd15, 1, 0, 1, 4'd1));
    end
    for (int c = 1; c <= 6; c++) begin
      if (c < 6) stepCycle(1'b0, 1'b1, 1'b0, mkExp(0, 0, 1, 4'd15, 1, 0, 1, 4'd1));
      else       stepCycle(1'b0, 1'b1, 1'b0, mkExp(0, 0, 1, 4'd15, 0, 0, 1, 4'd1));
    end

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
